// File: rtl/multi_edge_detector.sv
// multi_edge_detector: per-channel synchronised, glitch-filtered edge detector; sticky flags built only with MULTI_EDGE_DETECTOR_STICKY_EN
module multi_edge_detector #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 4
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_sclr,
  input  logic            i_en,
  input  logic [CH-1:0]   i_dat,
  input  logic [2*CH-1:0] i_mode,
  input  logic [CH-1:0]   i_ack,
  output logic [CH-1:0]   o_level,
  output logic [CH-1:0]   o_pulse,
  output logic [CH-1:0]   o_pending,
  output logic [CH-1:0]   o_overrun,
  output logic            o_irq
);
  localparam int CW = FILTER > 1 ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER - 1);
  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_n [CH];
  logic [CH-1:0] sdat, tog, pulse_n;
  assign sdat = sync_q[SYNC_STAGES-1];
  // synchroniser chain runs every cycle, independent of i_en
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n)
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    else if (i_sclr)
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    else begin
      sync_q[0] <= i_dat;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  // filter: a level is accepted once the mismatch has held FILTER enabled cycles
  always_comb begin
    tog = '0;
    pulse_n = '0;
    for (int c = 0; c < CH; c++) begin
      tog[c] = i_en && sdat[c] != o_level[c] && cnt_q[c] == LAST;
      pulse_n[c] = tog[c] && (sdat[c] ? i_mode[2*c] : i_mode[2*c+1]);
      cnt_n[c] = !i_en ? cnt_q[c] : (sdat[c] == o_level[c] || tog[c]) ? '0 : cnt_q[c] + 1'b1;
    end
  end
  // filtered level, counters and registered event pulse
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_level <= '0;
      o_pulse <= '0;
      for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
    end else if (i_sclr) begin
      o_level <= '0;
      o_pulse <= '0;
      for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
    end else begin
      o_level <= o_level ^ tog;
      o_pulse <= pulse_n;
      for (int c = 0; c < CH; c++) cnt_q[c] <= cnt_n[c];
    end
`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
  // sticky flags: a new event wins over a coincident ack; frozen while disabled
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_pending <= '0;
      o_overrun <= '0;
    end else if (i_sclr) begin
      o_pending <= '0;
      o_overrun <= '0;
    end else if (i_en) begin
      o_pending <= pulse_n | (o_pending & ~i_ack);
      o_overrun <= (pulse_n & o_pending) | (o_overrun & ~i_ack);
    end
  assign o_irq = |o_pending;
`else
  logic unused_ack;
  assign unused_ack = |i_ack;
  assign o_pending = '0;
  assign o_overrun = '0;
  assign o_irq = 1'b0;
`endif
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: directed self-checking bench for multi_edge_detector at default parameters
module tb_multi_edge_detector;
`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic clk = 1'b0;
  logic i_rst_n, i_sclr, i_en;
  logic [3:0] i_dat, i_ack;
  logic [7:0] i_mode;
  logic [3:0] o_level, o_pulse, o_pending, o_overrun;
  logic o_irq;
  int checks = 0;
  int errors = 0;

  multi_edge_detector dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_sclr(i_sclr), .i_en(i_en),
    .i_dat(i_dat), .i_mode(i_mode), .i_ack(i_ack),
    .o_level(o_level), .o_pulse(o_pulse), .o_pending(o_pending),
    .o_overrun(o_overrun), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sk(input logic [3:0] v);
    return STICKY ? v : 4'b0000;
  endfunction

  initial begin
    i_rst_n = 1'b0; i_sclr = 1'b0; i_en = 1'b1;
    i_dat = '0; i_ack = '0; i_mode = 8'b11_10_01_01;
    #2;
    chk("rst_level", o_level, 4'b0000);
    chk("rst_pulse", o_pulse, 4'b0000);
    chk("rst_pending", o_pending, 4'b0000);
    chk("rst_overrun", o_overrun, 4'b0000);
    chk("rst_irq", o_irq, 1'b0);
    step(2);
    i_rst_n = 1'b1;
    step(2);
    // ch0 rise, mode 01: level at edge 6, one-cycle pulse
    i_dat[0] = 1'b1;
    step(5);
    chk("t1_level_e5", o_level, 4'b0000);
    chk("t1_pulse_e5", o_pulse, 4'b0000);
    step(1);
    chk("t1_level_e6", o_level, 4'b0001);
    chk("t1_pulse_e6", o_pulse, 4'b0001);
    chk("t1_pending", o_pending, sk(4'b0001));
    chk("t1_irq", o_irq, STICKY);
    step(1);
    chk("t1_pulse_e7", o_pulse, 4'b0000);
    i_ack = 4'b0001;
    step(1);
    i_ack = '0;
    chk("t1_ack", o_pending, 4'b0000);
    // ch1 three-cycle glitch is filtered out
    i_dat[1] = 1'b1;
    step(3);
    i_dat[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t2_level", o_level, 4'b0001);
      chk("t2_pulse", o_pulse, 4'b0000);
    end
    chk("t2_pending", o_pending, 4'b0000);
    // ch2 mode 10: rise silent, fall pulses
    i_dat[2] = 1'b1;
    step(6);
    chk("t3_rise_level", o_level, 4'b0101);
    chk("t3_rise_pulse", o_pulse, 4'b0000);
    i_dat[2] = 1'b0;
    step(5);
    chk("t3_fall_e5", o_level, 4'b0101);
    step(1);
    chk("t3_fall_level", o_level, 4'b0001);
    chk("t3_fall_pulse", o_pulse, 4'b0100);
    step(1);
    chk("t3_fall_pulse_end", o_pulse, 4'b0000);
    // ch2 mode 11: both edges pulse
    i_mode[5:4] = 2'b11;
    i_dat[2] = 1'b1;
    step(6);
    chk("t3_both_rise", o_pulse, 4'b0100);
    step(1);
    chk("t3_both_rise_end", o_pulse, 4'b0000);
    i_dat[2] = 1'b0;
    step(6);
    chk("t3_both_fall", o_pulse, 4'b0100);
    chk("t3_overrun", o_overrun, sk(4'b0100));
    i_ack = 4'b1111;
    step(1);
    i_ack = '0;
    chk("t3_ack_pending", o_pending, 4'b0000);
    chk("t3_ack_overrun", o_overrun, 4'b0000);
    // ch3 sticky: pending, overrun, ack colliding with a third pulse
    i_dat[3] = 1'b1;
    step(6);
    chk("t4_p1_pulse", o_pulse, 4'b1000);
    chk("t4_p1_pending", o_pending, sk(4'b1000));
    chk("t4_p1_overrun", o_overrun, 4'b0000);
    i_dat[3] = 1'b0;
    step(6);
    chk("t4_p2_pulse", o_pulse, 4'b1000);
    chk("t4_p2_pending", o_pending, sk(4'b1000));
    chk("t4_p2_overrun", o_overrun, sk(4'b1000));
    chk("t4_p2_irq", o_irq, STICKY);
    i_dat[3] = 1'b1;
    step(5);
    i_ack = 4'b1000;
    step(1);
    i_ack = '0;
    chk("t4_p3_pulse", o_pulse, 4'b1000);
    chk("t4_p3_pending", o_pending, sk(4'b1000));
    chk("t4_p3_overrun", o_overrun, sk(4'b1000));
    i_ack = 4'b1000;
    step(1);
    i_ack = '0;
    chk("t4_ack_pending", o_pending, 4'b0000);
    chk("t4_ack_irq", o_irq, 1'b0);
    // disable freezes outputs; re-enable fires after FILTER cycles
    i_en = 1'b0;
    i_dat[1] = 1'b1;
    i_ack = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t5_frozen_level", o_level, 4'b1001);
      chk("t5_frozen_pulse", o_pulse, 4'b0000);
    end
    i_ack = '0;
    i_en = 1'b1;
    step(3);
    chk("t5_reen_e3", o_level, 4'b1001);
    step(1);
    chk("t5_reen_level", o_level, 4'b1011);
    chk("t5_reen_pulse", o_pulse, 4'b0010);
    chk("t5_reen_pending", o_pending, sk(4'b0010));
    step(1);
    // sync clear mid-filter with pending set
    i_dat[0] = 1'b0;
    step(3);
    i_sclr = 1'b1;
    i_en = 1'b1;
    i_ack = '0;
    step(1);
    i_sclr = 1'b0;
    chk("t6_sclr_level", o_level, 4'b0000);
    chk("t6_sclr_pulse", o_pulse, 4'b0000);
    chk("t6_sclr_pending", o_pending, 4'b0000);
    chk("t6_sclr_overrun", o_overrun, 4'b0000);
    chk("t6_sclr_irq", o_irq, 1'b0);
    step(5);
    chk("t6_reacq_e5", o_level, 4'b0000);
    step(1);
    chk("t6_reacq_level", o_level, 4'b1010);
    chk("t6_reacq_pulse", o_pulse, 4'b1010);
    chk("t6_reacq_pending", o_pending, sk(4'b1010));
    step(1);
    // async reset mid-filter
    i_dat[1] = 1'b0;
    step(3);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("t7_rst_level", o_level, 4'b0000);
    chk("t7_rst_pulse", o_pulse, 4'b0000);
    chk("t7_rst_pending", o_pending, 4'b0000);
    chk("t7_rst_overrun", o_overrun, 4'b0000);
    chk("t7_rst_irq", o_irq, 1'b0);
    step(2);
    i_rst_n = 1'b1;
    step(5);
    chk("t7_post_e5", o_level, 4'b0000);
    step(1);
    chk("t7_post_level", o_level, 4'b1000);
    chk("t7_post_pulse", o_pulse, 4'b1000);
    step(1);
    chk("t7_post_pulse_end", o_pulse, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_edge_detector.md
MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 The block SHALL have parameter CH, default 4, number of independent input channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per channel (>=2).
REQ-003 The block SHALL have parameter FILTER, default 4, consecutive cycles a new level must hold before it is accepted (>=1).
REQ-004 The block SHALL have port clk  in  1  rising-edge clock.
REQ-005 The block SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port i_sclr  in  1  synchronous clear.
REQ-007 The block SHALL have port i_en  in  1  detection/filter enable.
REQ-008 The block SHALL have port i_dat  in  CH  asynchronous channel inputs.
REQ-009 The block SHALL have port i_mode  in  2*CH  per-channel mode, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both.
REQ-010 The block SHALL have port i_ack  in  CH  per-channel pending clear.
REQ-011 The block SHALL have port o_level  out  CH  filtered level.
REQ-012 The block SHALL have port o_pulse  out  CH  one-cycle event pulse.
REQ-013 The block SHALL have port o_pending  out  CH  sticky event flag.
REQ-014 The block SHALL have port o_overrun  out  CH  event arrived while pending already set.
REQ-015 The block SHALL have port o_irq  out  1  OR of o_pending.

Function
REQ-016 Each channel SHALL pass i_dat through SYNC_STAGES flops clocked every cycle, regardless of i_en.
REQ-017 Per channel, when i_en=1 and sync output != o_level, the filter counter SHALL increment; when sync output == o_level, it SHALL return to 0.
REQ-018 When the counter is FILTER-1 and a mismatch is present with i_en=1, o_level SHALL toggle on that edge and the counter SHALL return to 0.
REQ-019 Latency: counting the first edge that samples a stable new i_dat as edge 1, o_level SHALL change at edge SYNC_STAGES+FILTER (edge 6 at defaults).
REQ-020 A mismatch shorter than FILTER cycles SHALL produce no o_level change and no pulse.
REQ-021 o_pulse[c] SHALL be registered and high for exactly the one cycle following an o_level toggle whose direction matches i_mode (rise 0->1, fall 1->0); o_level SHALL track regardless of mode.
REQ-022 i_mode SHALL be sampled at the toggle edge; a mode change affects only later toggles.
REQ-023 When i_en=0, counters, o_level, o_pending and o_overrun SHALL hold, and o_pulse SHALL be 0.
REQ-024 o_pending[c] SHALL set on any cycle o_pulse[c] is set and clear on i_ack[c]=1; when set and ack coincide, set SHALL win.
REQ-025 o_overrun[c] SHALL set when a pulse occurs while o_pending[c] is already 1, and SHALL clear with i_ack[c] under the same set-wins rule.
REQ-026 o_irq SHALL be the combinational OR of o_pending.
REQ-027 i_sclr=1 SHALL zero the sync flops, counters, o_level, o_pulse, o_pending and o_overrun on the next edge, taking priority over i_en and i_ack.
REQ-028 Channels SHALL be fully independent; simultaneous events on multiple channels SHALL all be reported in the same cycle.

Reset
REQ-029 When i_rst_n=0, all flops SHALL clear asynchronously: o_level=0, o_pulse=0, o_pending=0, o_overrun=0, o_irq=0.
REQ-030 After i_rst_n deasserts with i_dat[c]=1 held, the channel SHALL report a rising event after the REQ-019 latency.
REQ-031 Reset asserted mid-filter SHALL discard the partial count.

Configuration
REQ-032 With macro MULTI_EDGE_DETECTOR_STICKY_EN defined, o_pending, o_overrun and o_irq SHALL behave per REQ-024..026.
REQ-033 With the macro undefined, o_pending, o_overrun and o_irq SHALL be constant 0, i_ack SHALL be ignored, and no sticky flops SHALL be built.

Verification
REQ-034 The bench SHALL cover: defaults, ch0 mode 01, i_dat[0] 0->1 held -> o_level[0] rises at edge 6 and o_pulse[0]=1 for exactly one cycle.
REQ-035 The bench SHALL cover: 3-cycle high glitch on i_dat[1] with FILTER=4 -> no o_level, o_pulse or o_pending change.
REQ-036 The bench SHALL cover: mode 10 on ch2, rise then fall -> rise gives no pulse, fall gives one pulse; mode 11 -> two pulses.
REQ-037 The bench SHALL cover, with STICKY_EN: two events on ch3 without ack -> o_pending[3]=1, o_overrun[3]=1, o_irq=1; ack coinciding with a third pulse -> o_pending stays 1.
REQ-038 The bench SHALL cover: i_en=0 while i_dat toggles -> outputs frozen; re-enabled -> event after FILTER further cycles.
REQ-039 The bench SHALL cover: i_sclr and i_rst_n asserted mid-filter with pending set -> all outputs 0 (async for i_rst_n, next edge for i_sclr).
